// File: rtl/sd_vector_serializer_pkg.sv
// Shared definitions for the signed-digit vector serializer.
// Holds the 2-bit signed-digit encodings ({plus, minus}) and the FSM state type
// used by the top level.
package sd_vector_serializer_pkg;

   localparam logic [1:0] SD_POS     = 2'b10;
   localparam logic [1:0] SD_NEG     = 2'b01;
   localparam logic [1:0] SD_ZERO    = 2'b00;
   localparam logic [1:0] SD_INVALID = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StStream,
      StFinish
   } state_e;

endpackage

// File: rtl/sd_vector_serializer_if.sv
// Bus bundle of the signed-digit vector serializer.
// Carries the control inputs (enable, start, base_addr, num_words), the paired
// plus/minus RAM read port (rd_en, rd_addr, rd_plus, rd_minus) and the serial
// digit stream with its status (digit_out, digit_valid, last_digit, busy, done,
// digit_err).
// Modports: master = serializer side, slave = environment (RAM + controller).
interface sd_vector_serializer_if #(
   parameter int unsigned UNROLLING  = 64,
   parameter int unsigned ADDR_WIDTH = 7
) ();

   logic                  enable;
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH-1:0] num_words;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [UNROLLING-1:0]  rd_plus;
   logic [UNROLLING-1:0]  rd_minus;
   logic [1:0]            digit_out;
   logic                  digit_valid;
   logic                  last_digit;
   logic                  busy;
   logic                  done;
   logic                  digit_err;

   modport master (
      input  enable, start, base_addr, num_words, rd_plus, rd_minus,
      output rd_en, rd_addr, digit_out, digit_valid, last_digit, busy, done, digit_err
   );

   modport slave (
      output enable, start, base_addr, num_words, rd_plus, rd_minus,
      input  rd_en, rd_addr, digit_out, digit_valid, last_digit, busy, done, digit_err
   );

endinterface

// File: rtl/sd_vector_serializer_shift.sv
// sd_shift_unit: datapath of the serializer.
// Holds the plus/minus shift pair, a one-word prefetch buffer and the
// digit-in-word counter; presents the current MSB digit normalized (11 -> 00).
// Ports:
//   clk, asyn_reset       clock, asynchronous active-high reset
//   enable                global clock enable
//   load                  load shift pair from rd_plus/rd_minus, restart counter
//   capture               store rd_plus/rd_minus into the prefetch buffer
//   advance               consume the current digit (shift, or reload from buffer)
//   rd_plus, rd_minus     RAM read data
//   digit                 normalized MSB digit
//   invalid               MSB pair is the illegal 11 code
//   first, last           current digit is the first / last of its word
//   pbuf_full             prefetch buffer holds the next word
module sd_shift_unit
   import sd_vector_serializer_pkg::*;
#(
   parameter int unsigned UNROLLING = 64
) (
   input  logic                 clk,
   input  logic                 asyn_reset,
   input  logic                 enable,
   input  logic                 load,
   input  logic                 capture,
   input  logic                 advance,
   input  logic [UNROLLING-1:0] rd_plus,
   input  logic [UNROLLING-1:0] rd_minus,
   output logic [1:0]           digit,
   output logic                 invalid,
   output logic                 first,
   output logic                 last,
   output logic                 pbuf_full
);

   localparam int unsigned CntW = $clog2(UNROLLING);

   logic [UNROLLING-1:0] plus_q, minus_q;
   logic [UNROLLING-1:0] pbuf_plus_q, pbuf_minus_q;
   logic                 pbuf_full_q;
   logic [CntW-1:0]      cnt_q;
   logic [1:0]           raw;

   assign first     = (cnt_q == '0);
   assign last      = (cnt_q == CntW'(UNROLLING - 1));
   assign pbuf_full = pbuf_full_q;

   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         plus_q       <= '0;
         minus_q      <= '0;
         pbuf_plus_q  <= '0;
         pbuf_minus_q <= '0;
         pbuf_full_q  <= 1'b0;
         cnt_q        <= '0;
      end else if (enable) begin
         if (capture) begin
            pbuf_plus_q  <= rd_plus;
            pbuf_minus_q <= rd_minus;
            pbuf_full_q  <= 1'b1;
         end
         if (load) begin
            plus_q  <= rd_plus;
            minus_q <= rd_minus;
            cnt_q   <= '0;
         end else if (advance) begin
            // Word boundary: swap in the prefetched word so the stream has no gap.
            if (last && pbuf_full_q) begin
               plus_q      <= pbuf_plus_q;
               minus_q     <= pbuf_minus_q;
               pbuf_full_q <= 1'b0;
               cnt_q       <= '0;
            end else begin
               plus_q  <= plus_q << 1;
               minus_q <= minus_q << 1;
               cnt_q   <= cnt_q + CntW'(1);
            end
         end
      end
   end

   always_comb begin
      raw     = {plus_q[UNROLLING-1], minus_q[UNROLLING-1]};
      digit   = SD_ZERO;
      invalid = 1'b0;
      case (raw)
         SD_POS:     digit = SD_POS;
         SD_NEG:     digit = SD_NEG;
         SD_INVALID: invalid = 1'b1;
         default:    digit = SD_ZERO;
      endcase
   end

endmodule

// File: rtl/sd_vector_serializer.sv
// sd_vector_serializer: streams num_words signed-digit words, read from the
// paired plus/minus RAMs starting at base_addr, as a gapless MSB-first serial
// digit stream. The top level holds the FSM, the address and word counters and
// drives the RAM read port; the datapath lives in sd_shift_unit.
// Ports:
//   clk, asyn_reset   clock, asynchronous active-high reset
//   bus (master)      control, RAM read port and digit stream (see interface)
module sd_vector_serializer
   import sd_vector_serializer_pkg::*;
#(
   parameter int unsigned UNROLLING  = 64,
   parameter int unsigned ADDR_WIDTH = 7
) (
   input logic                   clk,
   input logic                   asyn_reset,
   sd_vector_serializer_if.master bus
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;   // next address to read
   logic [ADDR_WIDTH-1:0] words_q;  // words not yet fetched
   logic                  pf_pending_q;
   logic                  err_q;
   logic                  load, rd_req, stream;
   logic [1:0]            digit;
   logic                  invalid, first, last, pbuf_full;

   assign stream = (state_q == StStream);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      rd_req  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) state_d = (bus.num_words != '0) ? StFetch : StFinish;
         end
         StFetch: begin
            rd_req  = 1'b1;
            state_d = StLoad;
         end
         StLoad: begin
            load    = 1'b1;
            state_d = StStream;
         end
         StStream: begin
            // Prefetch right after a word is loaded; lands in the buffer well
            // before the word boundary since UNROLLING >= 3.
            rd_req = first && (words_q != '0) && !pbuf_full;
            if (last && !pbuf_full) state_d = StFinish;
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         words_q      <= '0;
         pf_pending_q <= 1'b0;
         err_q        <= 1'b0;
      end else if (bus.enable) begin
         state_q      <= state_d;
         pf_pending_q <= rd_req && stream;
         if (state_q == StIdle && bus.start) begin
            addr_q  <= bus.base_addr;
            words_q <= bus.num_words;
            err_q   <= 1'b0;
         end else begin
            if (rd_req) begin
               addr_q  <= addr_q + ADDR_WIDTH'(1);
               words_q <= words_q - ADDR_WIDTH'(1);
            end
            if (stream && invalid) err_q <= 1'b1;
         end
      end
   end

   sd_shift_unit #(
      .UNROLLING(UNROLLING)
   ) u_shift (
      .clk        (clk),
      .asyn_reset (asyn_reset),
      .enable     (bus.enable),
      .load       (load),
      .capture    (pf_pending_q),
      .advance    (stream),
      .rd_plus    (bus.rd_plus),
      .rd_minus   (bus.rd_minus),
      .digit      (digit),
      .invalid    (invalid),
      .first      (first),
      .last       (last),
      .pbuf_full  (pbuf_full)
   );

   assign bus.rd_en       = rd_req && bus.enable;
   assign bus.rd_addr     = addr_q;
   assign bus.digit_valid = stream;
   assign bus.digit_out   = stream ? digit : SD_ZERO;
   assign bus.last_digit  = stream && last && !pbuf_full;
   assign bus.busy        = (state_q == StFetch) || (state_q == StLoad) || stream;
   assign bus.done        = (state_q == StFinish);
   // The flag shows up alongside the offending digit, then stays sticky.
   assign bus.digit_err   = err_q || (stream && invalid);

endmodule
